prod_accumulator: RTL and testbench
===================================

Name: prod_accumulator

Overview:
- Downstream consumer of the 4x4 combinational array multiplier's 8-bit product (P7..P0 packed MSB-first).
- Accumulates a fixed-length block of products with valid/ready flow control and unsigned saturation.
- Emits one registered block sum per block, ready for the dot-product / filter stage that follows.

Parameters:
- ACC_W, 10, accumulator and result width in bits; legal range 8..16.
- BLOCK_LEN, 4, number of products summed per output; legal range 2..16.
- CNT_W, 4, beat-counter width; must satisfy 2^CNT_W >= BLOCK_LEN.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- clear  input  1  synchronous abort of the current block.
- in_valid  input  1  a product is presented.
- in_ready  output  1  accumulator can take a product this cycle.
- prod  input  8  unsigned multiplier product {P7..P0}.
- out_valid  output  1  out_data holds a completed block sum.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  ACC_W  saturated block sum.
- out_sat  output  1  saturation occurred during this block.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACC, acc=0, cnt=0, sat=0.
  - out_valid=0, out_data=0, out_sat=0, in_ready=1 while in reset-released ACC.
- States:
  - ACC: collecting products. in_ready=1, out_valid=0.
  - EMIT: holding the result. in_ready=0, out_valid=1.
- Transfer rules:
  - Input beat when in_valid & in_ready.
  - Output beat when out_valid & out_ready.
- ACC input beat:
  - sum = acc + zero-extended prod, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1: acc clamps to 2^ACC_W-1 and sat is set (sticky for the block).
  - cnt increments.
- Last beat (input beat with cnt==BLOCK_LEN-1):
  - out_data <= saturated sum; out_sat <= sat OR this beat's overflow.
  - Go to EMIT. out_valid is high on the next cycle, so latency from last accepted product to out_valid is 1 cycle.
- After saturation: acc stays clamped for the rest of the block. Further additions re-saturate and do not wrap.
- EMIT:
  - out_data and out_sat are held stable while out_valid=1 and out_ready=0. No change under backpressure.
  - On output beat: go to ACC, acc=0, cnt=0, sat=0, out_valid=0 next cycle.
  - out_data keeps its last value after the beat. It is don't-care while out_valid=0, but must not be X.
  - No input beat can occur in the same cycle as the output beat (in_ready=0 in EMIT). The block costs BLOCK_LEN+1 cycles minimum.
- Idle cycles in ACC (in_valid=0): acc and cnt hold. Gaps between products are legal.
- prod is sampled only on an input beat. Values while in_valid=0 are ignored.
- clear=1 (synchronous, highest priority, any state):
  - Next cycle: state=ACC, acc=0, cnt=0, sat=0, out_valid=0, out_sat=0.
  - A coincident input or output beat is discarded. The handshake signals still show the beat happening that cycle, but it has no effect.
- Reset mid-block or mid-EMIT: immediate return to reset values. A partial sum is lost and no output is produced.
- Arithmetic: unsigned only. prod range 0..225 for real multiplier outputs, but all 0..255 must be handled.

Decomposition:
- Shared package:
  - State enum (ACC, EMIT).
  - Constant PROD_W=8, matching the multiplier output width.
  - A saturate-add function of width ACC_W, reused by later accumulating stages.
- Sub-module sat_adder:
  - Combinational, operands (ACC_W-bit a, PROD_W-bit b), outputs (ACC_W-bit sum, ovf).
  - Instantiated once.
- FSM, counter and output registers live in prod_accumulator.

Test Plan:
- Basic block: BLOCK_LEN=4, products 15,30,45,60 on consecutive cycles, out_ready=1 -> out_valid pulses 1 cycle after 4th beat, out_data=150, out_sat=0, in_ready high again the following cycle.
- Gaps and backpressure: products 225,225,225,225 with idle cycles between, out_ready=0 for 5 cycles -> out_data=900 stable and in_ready=0 throughout hold; release -> one output beat only.
- Saturation: ACC_W=9 override, products 225,225,225,10 -> acc clamps 511 at 3rd beat, out_data=511, out_sat=1; next block of 1,1,1,1 -> out_data=4, out_sat=0.
- Clear mid-block: 100,100 accepted, then clear with in_valid=1, prod=50 -> beat discarded; then 1,2,3,4 -> out_data=10.
- Clear during EMIT: out_valid=1, clear with out_ready=1 -> out_valid=0 next cycle, state ACC, cnt=0, no stale result reappears.
- Async reset: assert rst_n=0 between clock edges after 2 beats -> outputs return to reset values without a clock edge; after release, full block of 5,5,5,5 -> out_data=20.

Source files
------------

// File: rtl/prod_accumulator_pkg.sv
// Shared types and arithmetic for the multiplier-product accumulation stages.
// Later accumulating stages reuse sat_add with their own accumulator width.
package prod_accumulator_pkg;

    localparam int PROD_W    = 8;
    localparam int ACC_MAX_W = 16;
    localparam int SUM_W     = ACC_MAX_W + 1;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ACC_MAX_W-1:0] sum;
        logic                 ovf;
    } sat_res_t;

    // Unsigned add of a product onto an accumulator of width acc_w (<= ACC_MAX_W),
    // clamping to the all-ones value of that width instead of wrapping.
    function automatic sat_res_t sat_add(
        input logic [ACC_MAX_W-1:0] a,
        input logic [PROD_W-1:0]    b,
        input int unsigned          acc_w
    );
        sat_res_t          res;
        logic [SUM_W-1:0]  full;
        logic [SUM_W-1:0]  lim;
        full = {1'b0, a} + {{(SUM_W-PROD_W){1'b0}}, b};
        lim  = ({{(SUM_W-1){1'b0}}, 1'b1} << acc_w) - {{(SUM_W-1){1'b0}}, 1'b1};
        if (full > lim) begin
            res.sum = lim[ACC_MAX_W-1:0];
            res.ovf = 1'b1;
        end else begin
            res.sum = full[ACC_MAX_W-1:0];
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/prod_accumulator_sat_adder.sv
// Combinational saturating adder: ACC_W-bit accumulator plus an 8-bit product.
module sat_adder
    import prod_accumulator_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    sat_res_t             res_s;
    logic [ACC_MAX_W-1:0] sum_unused_s;

    // Evaluate the shared saturate-add at this instance's width
    always_comb begin
        res_s = sat_add(ACC_MAX_W'(a), b, ACC_W);
    end

    assign sum          = res_s.sum[ACC_W-1:0];
    assign ovf          = res_s.ovf;
    assign sum_unused_s = res_s.sum;

endmodule

// File: rtl/prod_accumulator.sv
// Block accumulator for multiplier products: sums BLOCK_LEN products with
// unsigned saturation and hands one registered result downstream per block.
module prod_accumulator
    import prod_accumulator_pkg::*;
#(
    parameter int ACC_W     = 10,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] out_data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;
    logic             out_sat_r;

    logic [ACC_W-1:0] sum_s;
    logic             ovf_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             in_beat_s;
    logic             out_beat_s;
    logic             last_s;

    sat_adder #(
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .a   (acc_r),
        .b   (prod),
        .sum (sum_s),
        .ovf (ovf_s)
    );

    assign in_beat_s  = in_valid & in_ready_s;
    assign out_beat_s = out_valid_s & out_ready;
    assign last_s     = (cnt_r == CNT_W'(BLOCK_LEN - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; clear overrides any coincident beat
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ACC;
        end else begin
            case (state_r)
                ACC: begin
                    if (in_beat_s && last_s) begin
                        state_nxt_s = EMIT;
                    end else begin
                        state_nxt_s = ACC;
                    end
                end
                EMIT: begin
                    if (out_beat_s) begin
                        state_nxt_s = ACC;
                    end else begin
                        state_nxt_s = EMIT;
                    end
                end
                default: state_nxt_s = ACC;
            endcase
        end
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ACC:     in_ready_s  = 1'b1;
            EMIT:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Accumulator, beat counter, sticky saturation flag and result registers.
    // The running sum is zeroed as soon as the result is captured, since no
    // input can be accepted again until the block has been emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
            out_data_r <= {ACC_W{1'b0}};
            out_sat_r  <= 1'b0;
        end else if (clear) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
            out_data_r <= out_data_r;
            out_sat_r  <= 1'b0;
        end else if (in_beat_s) begin
            if (last_s) begin
                acc_r      <= {ACC_W{1'b0}};
                cnt_r      <= {CNT_W{1'b0}};
                sat_r      <= 1'b0;
                out_data_r <= sum_s;
                out_sat_r  <= sat_r | ovf_s;
            end else begin
                acc_r      <= sum_s;
                cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                sat_r      <= sat_r | ovf_s;
                out_data_r <= out_data_r;
                out_sat_r  <= out_sat_r;
            end
        end else if (out_beat_s) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
            out_data_r <= out_data_r;
            out_sat_r  <= out_sat_r;
        end else begin
            acc_r      <= acc_r;
            cnt_r      <= cnt_r;
            sat_r      <= sat_r;
            out_data_r <= out_data_r;
            out_sat_r  <= out_sat_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench: two accumulators (ACC_W=10 and ACC_W=9) share one stimulus
// stream and are compared against a block-level reference model.
module tb_prod_accumulator;

    localparam int BL    = 4;
    localparam int MAX_A = 1023;
    localparam int MAX_B = 511;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] prod = 8'd0;

    logic       in_ready_a, out_valid_a, out_sat_a;
    logic [9:0] out_data_a;
    logic       in_ready_b, out_valid_b, out_sat_b;
    logic [8:0] out_data_b;

    int total = 0;
    int bad   = 0;

    // reference model: products of the open block, and the pending result
    int blk[$];
    bit m_emit = 1'b0;
    int exp_a, exp_b;
    bit sat_a, sat_b;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(10), .BLOCK_LEN(BL), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_a), .prod(prod), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a)
    );

    prod_accumulator #(.ACC_W(9), .BLOCK_LEN(BL), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready_b), .prod(prod), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic void block_sum(input int maxv, output int s, output bit sat);
        s   = 0;
        sat = 1'b0;
        foreach (blk[i]) begin
            s = s + blk[i];
            if (s > maxv) begin
                s   = maxv;
                sat = 1'b1;
            end
        end
    endfunction

    // one clock: predict from the inputs in force, update model at the edge, compare
    task automatic step();
        bit ib, ob;
        ib = in_valid && !m_emit;
        ob = out_ready && m_emit;
        @(posedge clk);
        if (clear) begin
            blk.delete();
            m_emit = 1'b0;
        end else if (ib) begin
            blk.push_back(int'(prod));
            if (blk.size() == BL) begin
                block_sum(MAX_A, exp_a, sat_a);
                block_sum(MAX_B, exp_b, sat_b);
                blk.delete();
                m_emit = 1'b1;
            end
        end else if (ob) begin
            m_emit = 1'b0;
        end
        #1;
        check("in_ready_a",  32'(in_ready_a),  32'(!m_emit));
        check("in_ready_b",  32'(in_ready_b),  32'(!m_emit));
        check("out_valid_a", 32'(out_valid_a), 32'(m_emit));
        check("out_valid_b", 32'(out_valid_b), 32'(m_emit));
        check("known_a", 32'($isunknown({out_data_a, out_sat_a})), 32'd0);
        check("known_b", 32'($isunknown({out_data_b, out_sat_b})), 32'd0);
        if (m_emit) begin
            check("out_data_a", 32'(out_data_a), 32'(exp_a));
            check("out_sat_a",  32'(out_sat_a),  32'(sat_a));
            check("out_data_b", 32'(out_data_b), 32'(exp_b));
            check("out_sat_b",  32'(out_sat_b),  32'(sat_b));
        end
    endtask

    task automatic send(input int p);
        in_valid = 1'b1;
        prod     = 8'(p);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // reset state, observed without any clock edge
        #12;
        check("rst_in_ready",  32'(in_ready_a),  32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data",  32'(out_data_a),  32'd0);
        check("rst_out_sat",   32'(out_sat_a),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic block, consecutive beats, 1-cycle latency
        out_ready = 1'b1;
        send(15); send(30); send(45); send(60);
        check("basic_valid", 32'(out_valid_a), 32'd1);
        check("basic_sum",   32'(out_data_a),  32'd150);
        check("basic_sat",   32'(out_sat_a),   32'd0);
        step();
        check("basic_ready_again", 32'(in_ready_a), 32'd1);

        // gaps between products, then 5 cycles of backpressure
        out_ready = 1'b0;
        for (int i = 0; i < BL; i++) begin
            send(225);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_data",  32'(out_data_a), 32'd900);
            check("hold_ready", 32'(in_ready_a), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("one_beat", 32'(out_valid_a), 32'd0);
        step();
        step();

        // saturation in the 9-bit instance, sticky across an unsaturating last beat
        send(225); send(225); send(225); send(10);
        check("sat_data_b", 32'(out_data_b), 32'd511);
        check("sat_flag_b", 32'(out_sat_b),  32'd1);
        step();
        send(1); send(1); send(1); send(1);
        check("post_sat_data_b", 32'(out_data_b), 32'd4);
        check("post_sat_flag_b", 32'(out_sat_b),  32'd0);
        step();

        // clear mid-block discards the coincident beat
        send(100); send(100);
        clear    = 1'b1;
        in_valid = 1'b1;
        prod     = 8'd50;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        send(1); send(2); send(3); send(4);
        check("clear_mid_sum", 32'(out_data_a), 32'd10);
        step();

        // clear during EMIT beats a coincident output beat
        send(200); send(200); send(200); send(200);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_emit_valid", 32'(out_valid_b), 32'd0);
        check("clear_emit_sat",   32'(out_sat_b),   32'd0);
        step(); step();
        send(2); send(2); send(2); send(2);
        check("after_clear_sum", 32'(out_data_a), 32'd8);
        step();

        // asynchronous reset between edges after two beats
        send(9); send(9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid_a), 32'd0);
        check("arst_in_ready",  32'(in_ready_a),  32'd1);
        check("arst_out_data",  32'(out_data_a),  32'd0);
        check("arst_out_sat",   32'(out_sat_a),   32'd0);
        blk.delete();
        m_emit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(5); send(5); send(5); send(5);
        check("arst_block_sum", 32'(out_data_a), 32'd20);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            prod      = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            step();
        end
        clear    = 1'b0;
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
